// File: rtl/pll_pkg.sv
// Shared types, AdjustFreq encodings and default parameters for the PLL phase comparator.
package pll_pkg;

    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned DEADBAND_DEF   = 2;
    localparam int unsigned TIMEOUT_DEF    = 200;
    localparam int unsigned LOCK_COUNT_DEF = 4;

    localparam logic [1:0] ADJ_DEC  = 2'b00;
    localparam logic [1:0] ADJ_HOLD = 2'b01;
    localparam logic [1:0] ADJ_INC  = 2'b10;

    typedef enum logic [1:0] {
        StWaitEdge = 2'b00,
        StRefLeads = 2'b01,
        StVfoLeads = 2'b10
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic pulse_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/phase_comparator.sv
// Measures which of the reference and VFO clocks rises first and by how many Clock cycles,
// then issues a one-cycle frequency command to the VFO and tracks lock.
module phase_comparator
    import pll_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DEADBAND   = DEADBAND_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             RefClockIn,
    input  logic             VFOClockIn,
    output logic [1:0]       AdjustFreq,
    output logic             SampleCmd,
    output logic [CNT_W-1:0] PhaseError,
    output logic             Locked
);

    localparam int unsigned      LockW     = $clog2(LOCK_COUNT + 1);
    localparam logic [LockW-1:0] LockMax   = LockW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TimeoutV  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] DeadbandV = CNT_W'(DEADBAND);

    logic ref_pulse, vfo_pulse;

    edge_sync u_ref_sync (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .async_i (RefClockIn),
        .pulse_o (ref_pulse)
    );

    edge_sync u_vfo_sync (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .async_i (VFOClockIn),
        .pulse_o (vfo_pulse)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LockW-1:0] lock_q, lock_d;
    logic [1:0]       adj_q, adj_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             sample_q, sample_d;

    logic             dec_valid;
    logic [1:0]       dec_adj;
    logic [CNT_W-1:0] dec_err;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lock_d    = lock_q;
        adj_d     = adj_q;
        err_d     = err_q;
        sample_d  = 1'b0;
        dec_valid = 1'b0;
        dec_adj   = ADJ_HOLD;
        dec_err   = '0;
        // The error includes the cycle in which the closing edge arrives.
        cnt_inc   = (cnt_q >= TimeoutV) ? TimeoutV : cnt_q + CNT_W'(1);

        unique case (state_q)
            StWaitEdge: begin
                if (ref_pulse && vfo_pulse) begin
                    dec_valid = 1'b1;
                end else if (ref_pulse) begin
                    state_d = StRefLeads;
                    cnt_d   = '0;
                end else if (vfo_pulse) begin
                    state_d = StVfoLeads;
                    cnt_d   = '0;
                end
            end
            StRefLeads: begin
                if (vfo_pulse) begin
                    dec_valid = 1'b1;
                    dec_err   = cnt_inc;
                    dec_adj   = (cnt_inc <= DeadbandV) ? ADJ_HOLD : ADJ_INC;
                    cnt_d     = '0;
                    state_d   = ref_pulse ? StRefLeads : StWaitEdge;
                end else if (ref_pulse) begin
                    dec_valid = 1'b1;
                    dec_err   = cnt_inc;
                    dec_adj   = ADJ_INC;
                    cnt_d     = '0;
                end else if (cnt_inc == TimeoutV) begin
                    state_d = StWaitEdge;
                    cnt_d   = '0;
                    lock_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StVfoLeads: begin
                if (ref_pulse) begin
                    dec_valid = 1'b1;
                    dec_err   = cnt_inc;
                    dec_adj   = (cnt_inc <= DeadbandV) ? ADJ_HOLD : ADJ_DEC;
                    cnt_d     = '0;
                    state_d   = vfo_pulse ? StVfoLeads : StWaitEdge;
                end else if (vfo_pulse) begin
                    dec_valid = 1'b1;
                    dec_err   = cnt_inc;
                    dec_adj   = ADJ_DEC;
                    cnt_d     = '0;
                end else if (cnt_inc == TimeoutV) begin
                    state_d = StWaitEdge;
                    cnt_d   = '0;
                    lock_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StWaitEdge;
                cnt_d   = '0;
            end
        endcase

        if (dec_valid) begin
            adj_d    = dec_adj;
            err_d    = dec_err;
            sample_d = 1'b1;
            if (dec_adj == ADJ_HOLD) begin
                lock_d = (lock_q == LockMax) ? LockMax : lock_q + LockW'(1);
            end else begin
                lock_d = '0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StWaitEdge;
            cnt_q    <= '0;
            lock_q   <= '0;
            adj_q    <= ADJ_HOLD;
            err_q    <= '0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lock_q   <= lock_d;
            adj_q    <= adj_d;
            err_q    <= err_d;
            sample_q <= sample_d;
        end
    end

    assign AdjustFreq = adj_q;
    assign SampleCmd  = sample_q;
    assign PhaseError = err_q;
    assign Locked     = (lock_q == LockMax);

endmodule

// File: tb/tb_phase_comparator.sv
// Bench for phase_comparator: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_phase_comparator;

    localparam int CNT_W      = 8;
    localparam int DEADBAND   = 2;
    localparam int TIMEOUT    = 200;
    localparam int LOCK_COUNT = 4;
    localparam int LATENCY    = 3;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             RefClockIn = 1'b0;
    logic             VFOClockIn = 1'b0;
    logic [1:0]       AdjustFreq;
    logic             SampleCmd;
    logic [CNT_W-1:0] PhaseError;
    logic             Locked;

    phase_comparator #(
        .CNT_W      (CNT_W),
        .DEADBAND   (DEADBAND),
        .TIMEOUT    (TIMEOUT),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .Clock      (clk),
        .Reset      (Reset),
        .RefClockIn (RefClockIn),
        .VFOClockIn (VFOClockIn),
        .AdjustFreq (AdjustFreq),
        .SampleCmd  (SampleCmd),
        .PhaseError (PhaseError),
        .Locked     (Locked)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an open measurement is a side plus the cycle it opened; the error
    // of any decision is simply the number of cycles since then.
    typedef enum int {SideNone, SideRef, SideVfo} side_e;

    bit         live = 1'b0;
    int         t = 0;
    side_e      side = SideNone;
    int         open_t = 0;
    int         lock_n = 0;
    logic [1:0] e_adj = 2'b01;
    int         e_err = 0;
    bit         e_samp = 1'b0;
    bit         prev_r = 1'b0;
    bit         prev_v = 1'b0;
    bit [1:0]   rise_dly [LATENCY];

    task automatic decide(input logic [1:0] a, input int e);
        e_adj  = a;
        e_err  = e;
        e_samp = 1'b1;
        if (a == 2'b01) lock_n = (lock_n < LOCK_COUNT) ? lock_n + 1 : LOCK_COUNT;
        else            lock_n = 0;
    endtask

    always @(posedge clk) begin : model
        bit r, v, r_now, v_now;
        int gap;
        t++;
        if (Reset) begin
            live   = 1'b1;
            side   = SideNone;
            lock_n = 0;
            e_adj  = 2'b01;
            e_err  = 0;
            e_samp = 1'b0;
            prev_r = 1'b0;
            prev_v = 1'b0;
            for (int i = 0; i < LATENCY; i++) rise_dly[i] = 2'b00;
        end else begin
            r_now  = RefClockIn && !prev_r;
            v_now  = VFOClockIn && !prev_v;
            prev_r = RefClockIn;
            prev_v = VFOClockIn;
            {r, v} = rise_dly[LATENCY-1];
            for (int i = LATENCY - 1; i > 0; i--) rise_dly[i] = rise_dly[i-1];
            rise_dly[0] = {r_now, v_now};
            e_samp = 1'b0;
            gap    = t - open_t;
            case (side)
                SideNone: begin
                    if (r && v) decide(2'b01, 0);
                    else if (r) begin side = SideRef; open_t = t; end
                    else if (v) begin side = SideVfo; open_t = t; end
                end
                SideRef: begin
                    if (v) begin
                        decide((gap <= DEADBAND) ? 2'b01 : 2'b10, gap);
                        if (r) open_t = t;
                        else side = SideNone;
                    end else if (r) begin
                        decide(2'b10, gap);
                        open_t = t;
                    end else if (gap >= TIMEOUT) begin
                        side = SideNone;
                        lock_n = 0;
                    end
                end
                SideVfo: begin
                    if (r) begin
                        decide((gap <= DEADBAND) ? 2'b01 : 2'b00, gap);
                        if (v) open_t = t;
                        else side = SideNone;
                    end else if (v) begin
                        decide(2'b00, gap);
                        open_t = t;
                    end else if (gap >= TIMEOUT) begin
                        side = SideNone;
                        lock_n = 0;
                    end
                end
                default: side = SideNone;
            endcase
        end
    end

    int         n_samp = 0;
    logic [1:0] last_adj = 2'b11;
    int         last_err = -1;

    always @(negedge clk) begin
        if (live) begin
            check("SampleCmd", 32'(SampleCmd), 32'(e_samp));
            check("AdjustFreq", 32'(AdjustFreq), 32'(e_adj));
            check("PhaseError", 32'(PhaseError), e_err);
            check("Locked", 32'(Locked), 32'(lock_n == LOCK_COUNT));
            if (SampleCmd === 1'b1) begin
                n_samp++;
                last_adj = AdjustFreq;
                last_err = int'(PhaseError);
            end
        end
    end

    task automatic set_in(input logic r, input logic v, input int n);
        @(negedge clk);
        RefClockIn = r;
        VFOClockIn = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_adj"}, 32'(AdjustFreq), 32'(2'b01));
        check({tag, "_err"}, 32'(PhaseError), 0);
        check({tag, "_samp"}, 32'(SampleCmd), 0);
        check({tag, "_locked"}, 32'(Locked), 0);
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        Reset = 1'b0;
        check_reset_outputs("reset");

        // Ref leads VFO by 10 cycles.
        s0 = n_samp;
        set_in(1, 0, 10);
        set_in(1, 1, 3);
        set_in(0, 0, 10);
        check("ref_lead_count", n_samp - s0, 1);
        check("ref_lead_adj", 32'(last_adj), 32'(2'b10));
        check("ref_lead_err", last_err, 10);

        // VFO leads by 1 cycle, inside the deadband: lock after the 4th decision.
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 1, 1);
            set_in(1, 1, 3);
            set_in(0, 0, 10);
            check("deadband_locked", 32'(Locked), 32'(i >= LOCK_COUNT));
        end
        check("deadband_adj", 32'(last_adj), 32'(2'b01));
        check("deadband_err", last_err, 1);
        check("model_lock", 32'(lock_n), LOCK_COUNT);

        // Ref alone: measurement times out silently and drops lock.
        s0 = n_samp;
        set_in(1, 0, 3);
        set_in(0, 0, 215);
        check("timeout_count", n_samp - s0, 0);
        check("timeout_locked", 32'(Locked), 0);

        // Simultaneous edges.
        s0 = n_samp;
        set_in(1, 1, 3);
        set_in(0, 0, 10);
        check("same_cycle_count", n_samp - s0, 1);
        check("same_cycle_adj", 32'(last_adj), 32'(2'b01));
        check("same_cycle_err", last_err, 0);

        // Two VFO edges 20 cycles apart with no ref edge.
        set_in(0, 1, 3);
        set_in(0, 0, 17);
        set_in(0, 1, 3);
        set_in(0, 0, 10);
        check("vfo_twice_adj", 32'(last_adj), 32'(2'b00));
        check("vfo_twice_err", last_err, 20);
        set_in(0, 0, 210);

        // Reset 5 cycles into REF_LEADS, then a lone VFO edge opens VFO_LEADS.
        s0 = n_samp;
        set_in(1, 0, 3);
        set_in(0, 0, 6);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check_reset_outputs("mid_reset");
        set_in(0, 1, 4);
        check("mid_reset_count", n_samp - s0, 0);
        set_in(1, 1, 3);
        set_in(0, 0, 10);
        check("after_reset_count", n_samp - s0, 1);
        check("after_reset_adj", 32'(last_adj), 32'(2'b00));
        check("after_reset_err", last_err, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
